// File: rtl/vector_div_256bit_pkg.sv
// Shared vector package: element-width encoding, VLEN and segmented bit helpers.
// Optional signed support is built with VDIV_SIGNED_EN.
package vec_pkg;

   localparam int VLEN = 256;

   typedef enum logic [2:0] {
      SEW8  = 3'b000,
      SEW16 = 3'b001,
      SEW32 = 3'b010,
      SEW64 = 3'b011
   } sew_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
`ifdef VDIV_SIGNED_EN
      ST_FIXUP = 2'd2,
`endif
      ST_DONE  = 2'd3
   } state_e;

   function automatic int unsigned sew_bits(input sew_e sew);
      case (sew)
         SEW8:    return 32'd8;
         SEW16:   return 32'd16;
         SEW32:   return 32'd32;
         SEW64:   return 32'd64;
         default: return 32'd0;
      endcase
   endfunction

   // One bit set at the least significant bit of every element in a 64-bit slice.
   function automatic logic [63:0] lsb_mask(input sew_e sew);
      case (sew)
         SEW8:    return 64'h0101_0101_0101_0101;
         SEW16:   return 64'h0001_0001_0001_0001;
         SEW32:   return 64'h0000_0001_0000_0001;
         default: return 64'h0000_0000_0000_0001;
      endcase
   endfunction

   function automatic logic [63:0] msb_mask(input sew_e sew);
      logic [63:0] l;
      l = lsb_mask(sew);
      return {l[0], l[63:1]};
   endfunction

   // Copy the bit found at each element MSB across the whole element.
   function automatic logic [63:0] spread(input logic [63:0] v, input logic [63:0] msb);
      logic        cur;
      logic [63:0] y;
      cur = 1'b0;
      y   = 64'd0;
      for (int j = 63; j >= 0; j--) begin
         if (msb[j]) cur = v[j];
         else        cur = cur;
         y[j] = cur;
      end
      return y;
   endfunction

   // Two's-complement negate the elements selected by sel; carries stop at element boundaries.
   function automatic logic [63:0] neg_seg(input logic [63:0] x, input logic [63:0] lsb,
                                           input logic [63:0] sel);
      logic        c;
      logic [63:0] y;
      c = 1'b0;
      y = x;
      for (int j = 0; j < 64; j++) begin
         if (lsb[j]) c = 1'b1;
         else        c = c;
         y[j] = sel[j] ? (~x[j] ^ c) : x[j];
         c    = ~x[j] & c;
      end
      return y;
   endfunction

   function automatic logic [63:0] any_seg(input logic [63:0] x, input logic [63:0] lsb,
                                           input logic [63:0] msb);
      logic        acc;
      logic [63:0] flag;
      acc  = 1'b0;
      flag = 64'd0;
      for (int j = 0; j < 64; j++) begin
         acc     = lsb[j] ? x[j] : (acc | x[j]);
         flag[j] = acc;
      end
      return spread(flag, msb);
   endfunction

endpackage

// File: rtl/vector_div_256bit_if.sv
// Operand/result handshake bundle for vector_div_256bit.
// signed_i exists only when VDIV_SIGNED_EN is defined.
interface vector_div_256bit_if;
   logic                     valid_i;
   logic                     ready_o;
   logic [vec_pkg::VLEN-1:0] a_i;
   logic [vec_pkg::VLEN-1:0] b_i;
   logic [2:0]               sew_i;
   logic                     rem_i;
`ifdef VDIV_SIGNED_EN
   logic                     signed_i;
`endif
   logic                     valid_o;
   logic                     ready_i;
   logic [vec_pkg::VLEN-1:0] out_o;

   modport slave (
`ifdef VDIV_SIGNED_EN
      input  signed_i,
`endif
      input  valid_i, a_i, b_i, sew_i, rem_i, ready_i,
      output ready_o, valid_o, out_o
   );

   modport master (
`ifdef VDIV_SIGNED_EN
      output signed_i,
`endif
      output valid_i, a_i, b_i, sew_i, rem_i, ready_i,
      input  ready_o, valid_o, out_o
   );
endinterface

// File: rtl/vector_div_256bit_lane.sv
// One 64-bit slice of the divider: segmented restoring shift/subtract step,
// plus magnitude conversion and sign fixup when VDIV_SIGNED_EN is defined.
module div_lane_64bit
   import vec_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        step_i,
`ifdef VDIV_SIGNED_EN
   input  logic        fixup_i,
   input  logic        signed_i,
`endif
   input  sew_e        sew_i,
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   output logic [63:0] quo_o,
   output logic [63:0] rem_o
);
   sew_e        sew_q, sew_d;
   logic [63:0] quo_q, quo_d, rem_q, rem_d, div_q, div_d;
   logic [63:0] lsb_s, msb_s, sh_r_s, diff_s, ge_s, new_r_s, new_q_s;
   logic        borrow_s, bin_s;
   int unsigned w_s;
`ifdef VDIV_SIGNED_EN
   logic [63:0] nega_q, nega_d, negb_q, negb_d, a_neg_s, b_neg_s;
`endif

   // One radix-2 step: the dividend drains out of quo into rem while quotient bits fill in.
   // A zero divisor always succeeds, leaving all-ones quotient and the dividend as remainder.
   always_comb begin
      lsb_s    = lsb_mask(sew_q);
      msb_s    = msb_mask(sew_q);
      w_s      = sew_bits(sew_q);
      sh_r_s   = ((rem_q << 1) & ~lsb_s) | ((quo_q >> (w_s - 32'd1)) & lsb_s);
      diff_s   = 64'd0;
      ge_s     = 64'd0;
      borrow_s = 1'b0;
      bin_s    = 1'b0;
      for (int j = 0; j < 64; j++) begin
         bin_s     = lsb_s[j] ? 1'b0 : borrow_s;
         diff_s[j] = sh_r_s[j] ^ div_q[j] ^ bin_s;
         borrow_s  = (~sh_r_s[j] & div_q[j]) | (~(sh_r_s[j] ^ div_q[j]) & bin_s);
         ge_s[j]   = rem_q[j] | ~borrow_s;
      end
      ge_s    = spread(ge_s, msb_s);
      new_r_s = (ge_s & diff_s) | (~ge_s & sh_r_s);
      new_q_s = ((quo_q << 1) & ~lsb_s) | (ge_s & lsb_s);
   end

   // Next-state selection: capture, divide step, sign fixup or hold.
   always_comb begin
      sew_d = sew_q;
      quo_d = quo_q;
      rem_d = rem_q;
      div_d = div_q;
`ifdef VDIV_SIGNED_EN
      nega_d  = nega_q;
      negb_d  = negb_q;
      a_neg_s = signed_i ? spread(a_i, msb_mask(sew_i)) : 64'd0;
      b_neg_s = signed_i ? spread(b_i, msb_mask(sew_i)) : 64'd0;
`endif
      if (load_i) begin
         sew_d = sew_i;
         rem_d = 64'd0;
`ifdef VDIV_SIGNED_EN
         nega_d = a_neg_s;
         negb_d = b_neg_s;
         quo_d  = neg_seg(a_i, lsb_mask(sew_i), a_neg_s);
         div_d  = neg_seg(b_i, lsb_mask(sew_i), b_neg_s);
`else
         quo_d = a_i;
         div_d = b_i;
`endif
      end else if (step_i) begin
         quo_d = new_q_s;
         rem_d = new_r_s;
      end
`ifdef VDIV_SIGNED_EN
      // A zero divisor keeps the all-ones quotient (-1); the remainder follows the dividend sign.
      else if (fixup_i) begin
         quo_d = neg_seg(quo_q, lsb_s, (nega_q ^ negb_q) & any_seg(div_q, lsb_s, msb_s));
         rem_d = neg_seg(rem_q, lsb_s, nega_q);
      end
`endif
      else begin
         quo_d = quo_q;
         rem_d = rem_q;
      end
   end

   // Slice state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sew_q  <= SEW8;
         quo_q  <= 64'd0;
         rem_q  <= 64'd0;
         div_q  <= 64'd0;
`ifdef VDIV_SIGNED_EN
         nega_q <= 64'd0;
         negb_q <= 64'd0;
`endif
      end else begin
         sew_q  <= sew_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         div_q  <= div_d;
`ifdef VDIV_SIGNED_EN
         nega_q <= nega_d;
         negb_q <= negb_d;
`endif
      end
   end

   assign quo_o = quo_q;
   assign rem_o = rem_q;
endmodule

// File: rtl/vector_div_256bit.sv
// Iterative packed vector divider: FSM, bit counter, handshake and result mux.
// VDIV_SIGNED_EN adds signed_i and a FIXUP state between BUSY and DONE.
module vector_div_256bit
   import vec_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   vector_div_256bit_if.slave bus
);
   localparam int NLANE = VLEN / 64;

   state_e          state_q, state_d;
   logic [6:0]      cnt_q, cnt_d;
   logic            rem_q, rem_d, rsv_q, rsv_d;
   logic            ready_q, ready_d, valid_q, valid_d;
   logic            load_s, step_s;
   logic [VLEN-1:0] quo_s, rems_s;
`ifdef VDIV_SIGNED_EN
   logic            fixup_s;
`endif

   // Next-state and control decode; a reserved width makes one idle pass through BUSY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      rsv_d   = rsv_q;
      load_s  = 1'b0;
      step_s  = 1'b0;
`ifdef VDIV_SIGNED_EN
      fixup_s = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.valid_i && ready_q) begin
               load_s  = 1'b1;
               rem_d   = bus.rem_i;
               rsv_d   = bus.sew_i[2];
               cnt_d   = bus.sew_i[2] ? 7'd1 : 7'(sew_bits(sew_e'(bus.sew_i)));
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            step_s = ~rsv_q;
            cnt_d  = cnt_q - 7'd1;
            if (cnt_q == 7'd1) begin
`ifdef VDIV_SIGNED_EN
               state_d = ST_FIXUP;
`else
               state_d = ST_DONE;
`endif
            end else begin
               state_d = ST_BUSY;
            end
         end
`ifdef VDIV_SIGNED_EN
         ST_FIXUP: begin
            fixup_s = 1'b1;
            state_d = ST_DONE;
         end
`endif
         ST_DONE: begin
            if (bus.ready_i) state_d = ST_IDLE;
            else             state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
      valid_d = (state_d == ST_DONE);
   end

   // Control registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 7'd0;
         rem_q   <= 1'b0;
         rsv_q   <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         rsv_q   <= rsv_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   for (genvar i = 0; i < NLANE; i++) begin : g_lane
      div_lane_64bit u_lane (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .load_i   (load_s),
         .step_i   (step_s),
`ifdef VDIV_SIGNED_EN
         .fixup_i  (fixup_s),
         .signed_i (bus.signed_i),
`endif
         .sew_i    (sew_e'(bus.sew_i)),
         .a_i      (bus.a_i[64*i +: 64]),
         .b_i      (bus.b_i[64*i +: 64]),
         .quo_o    (quo_s[64*i +: 64]),
         .rem_o    (rems_s[64*i +: 64])
      );
   end

   assign bus.ready_o = ready_q;
   assign bus.valid_o = valid_q;
   assign bus.out_o   = rsv_q ? {VLEN{1'b0}} : (rem_q ? rems_s : quo_s);
endmodule

// File: tb/tb_vector_div_256bit.sv
// Directed self-checking bench for vector_div_256bit (also covers VDIV_SIGNED_EN builds).
module tb_vector_div_256bit;
   import vec_pkg::*;

`ifdef VDIV_SIGNED_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   vector_div_256bit_if bus ();
   vector_div_256bit dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic drive_idle();
      bus.valid_i = 1'b0;
      bus.a_i     = '0;
      bus.b_i     = '0;
      bus.sew_i   = 3'b000;
      bus.rem_i   = 1'b0;
      bus.ready_i = 1'b0;
`ifdef VDIV_SIGNED_EN
      bus.signed_i = 1'b0;
`endif
   endtask

   // Called #1 after a posedge with the DUT idle; returns the result and latency in cycles.
   task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [2:0] sew,
                         input logic rem, output logic [255:0] res, output int lat);
      bus.a_i     = a;
      bus.b_i     = b;
      bus.sew_i   = sew;
      bus.rem_i   = rem;
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      lat = 1;
      while (bus.valid_o !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = bus.out_o;
   endtask

   task automatic finish_op();
      bus.ready_i = 1'b1;
      @(posedge clk); #1;
      bus.ready_i = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready_o); end
      checks++;
      if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid_o); end
      checks++;
      if (bus.out_o !== 256'd0) begin errors++; $display("FAIL reset_out: got %h expected 0", bus.out_o); end
   endtask

   task automatic test_sew8();
      logic [255:0] res, exp;
      int lat;
      run_op({32{8'd200}}, {32{8'd7}}, 3'b000, 1'b0, res, lat);
      exp = {32{8'h1C}};
      checks++;
      if (res !== exp) begin errors++; $display("FAIL sew8_quo: got %h expected %h", res, exp); end
      checks++;
      if (lat != 9 + EXTRA) begin errors++; $display("FAIL sew8_latency: got %0d expected %0d", lat, 9 + EXTRA); end
      finish_op();
      run_op({32{8'd200}}, {32{8'd7}}, 3'b000, 1'b1, res, lat);
      exp = {32{8'h04}};
      checks++;
      if (res !== exp) begin errors++; $display("FAIL sew8_rem: got %h expected %h", res, exp); end
      finish_op();
   endtask

   task automatic test_sew64();
      logic [255:0] a, b, res, exp;
      int lat;
      a = '0;
      b = {4{64'd1}};
      a[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
      b[63:0] = 64'd3;
      run_op(a, b, 3'b011, 1'b0, res, lat);
      exp = '0;
      exp[63:0] = 64'h5555_5555_5555_5555;
      checks++;
      if (res !== exp) begin errors++; $display("FAIL sew64_quo: got %h expected %h", res, exp); end
      checks++;
      if (lat != 65 + EXTRA) begin errors++; $display("FAIL sew64_latency: got %0d expected %0d", lat, 65 + EXTRA); end
      finish_op();
      run_op(a, b, 3'b011, 1'b1, res, lat);
      checks++;
      if (res !== 256'd0) begin errors++; $display("FAIL sew64_rem: got %h expected 0", res); end
      finish_op();
   endtask

   task automatic test_sew32();
      logic [255:0] a, b, res, exp;
      int lat;
      a = '0;
      b = {8{32'd1}};
      a[31:0]  = 32'd100;         b[31:0]  = 32'd10;
      a[63:32] = 32'hFFFF_FFFF;   b[63:32] = 32'hFFFF_FFFF;
      a[95:64] = 32'd7;           b[95:64] = 32'hFFFF_FFFF;
      run_op(a, b, 3'b010, 1'b0, res, lat);
      exp = '0;
      exp[31:0]  = 32'd10;
      exp[63:32] = 32'd1;
      checks++;
      if (res !== exp) begin errors++; $display("FAIL sew32_quo: got %h expected %h", res, exp); end
      checks++;
      if (lat != 33 + EXTRA) begin errors++; $display("FAIL sew32_latency: got %0d expected %0d", lat, 33 + EXTRA); end
      finish_op();
      run_op(a, b, 3'b010, 1'b1, res, lat);
      exp = '0;
      exp[95:64] = 32'd7;
      checks++;
      if (res !== exp) begin errors++; $display("FAIL sew32_rem: got %h expected %h", res, exp); end
      finish_op();
   endtask

   task automatic test_div_zero();
      logic [255:0] a, b, res, exp;
      int lat;
      a = '0;
      b = {16{16'd1}};
      a[15:0]  = 16'h1234; b[15:0]  = 16'h0000;
      a[31:16] = 16'hFFFF; b[31:16] = 16'h0000;
      run_op(a, b, 3'b001, 1'b0, res, lat);
      exp = '0;
      exp[31:0] = 32'hFFFF_FFFF;
      checks++;
      if (res !== exp) begin errors++; $display("FAIL divzero_quo: got %h expected %h", res, exp); end
      checks++;
      if (lat != 17 + EXTRA) begin errors++; $display("FAIL divzero_latency: got %0d expected %0d", lat, 17 + EXTRA); end
      finish_op();
      run_op(a, b, 3'b001, 1'b1, res, lat);
      exp = '0;
      exp[31:0] = 32'hFFFF_1234;
      checks++;
      if (res !== exp) begin errors++; $display("FAIL divzero_rem: got %h expected %h", res, exp); end
      finish_op();
   endtask

   task automatic test_reserved();
      logic [255:0] res;
      int lat;
      run_op({32{8'd200}}, {32{8'd7}}, 3'b101, 1'b0, res, lat);
      checks++;
      if (res !== 256'd0) begin errors++; $display("FAIL reserved_out: got %h expected 0", res); end
      checks++;
      if (lat != 2 + EXTRA) begin errors++; $display("FAIL reserved_latency: got %0d expected %0d", lat, 2 + EXTRA); end
      finish_op();
   endtask

   task automatic test_backpressure();
      logic [255:0] res, exp;
      int lat;
      exp = {32{8'h1C}};
      run_op({32{8'd200}}, {32{8'd7}}, 3'b000, 1'b0, res, lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.valid_o !== 1'b1 || bus.out_o !== exp || bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: got valid=%b ready=%b out=%h expected valid=1 ready=0 out=%h",
                     i, bus.valid_o, bus.ready_o, bus.out_o, exp);
         end
      end
      finish_op();
      checks++;
      if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL release_valid: got %b expected 0", bus.valid_o); end
      checks++;
      if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", bus.ready_o); end
   endtask

   task automatic test_ignore_inputs();
      int lat;
      bus.a_i     = {32{8'd200}};
      bus.b_i     = {32{8'd7}};
      bus.sew_i   = 3'b000;
      bus.rem_i   = 1'b0;
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
      bus.a_i   = {32{8'd50}};
      bus.b_i   = {32{8'd3}};
      bus.sew_i = 3'b011;
      bus.rem_i = 1'b1;
      checks++;
      if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", bus.ready_o); end
      lat = 1;
      while (bus.valid_o !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      bus.valid_i = 1'b0;
      checks++;
      if (bus.out_o !== {32{8'h1C}} || lat != 9 + EXTRA) begin
         errors++;
         $display("FAIL ignore_inputs: got out=%h lat=%0d expected out=%h lat=%0d",
                  bus.out_o, lat, {32{8'h1C}}, 9 + EXTRA);
      end
      finish_op();
      drive_idle();
   endtask

   task automatic test_reset_mid();
      logic [255:0] a, b, res;
      int lat;
      int seen;
      a = '0;
      b = {4{64'd1}};
      a[63:0] = 64'hFFFF_FFFF_FFFF_FFFF;
      b[63:0] = 64'd3;
      bus.a_i = a; bus.b_i = b; bus.sew_i = 3'b011; bus.rem_i = 1'b0; bus.valid_i = 1'b1;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
         errors++;
         $display("FAIL busy_reset: got valid=%b ready=%b expected valid=0 ready=1", bus.valid_o, bus.ready_o);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (bus.valid_o !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL busy_reset_no_result: got %0d valid cycles expected 0", seen); end
      checks++;
      if (bus.ready_o !== 1'b1 || bus.out_o !== 256'd0) begin
         errors++;
         $display("FAIL busy_reset_state: got ready=%b out=%h expected ready=1 out=0", bus.ready_o, bus.out_o);
      end
      run_op({32{8'd200}}, {32{8'd7}}, 3'b000, 1'b0, res, lat);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL done_reset_valid: got %b expected 0", bus.valid_o); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

`ifdef VDIV_SIGNED_EN
   task automatic test_signed();
      logic [255:0] res, exp;
      int lat;
      bus.signed_i = 1'b1;
      run_op({32{8'h80}}, {32{8'hFF}}, 3'b000, 1'b0, res, lat);
      exp = {32{8'h80}};
      checks++;
      if (res !== exp) begin errors++; $display("FAIL signed_ovf_quo: got %h expected %h", res, exp); end
      checks++;
      if (lat != 10) begin errors++; $display("FAIL signed_latency: got %0d expected 10", lat); end
      finish_op();
      run_op({32{8'h80}}, {32{8'hFF}}, 3'b000, 1'b1, res, lat);
      checks++;
      if (res !== 256'd0) begin errors++; $display("FAIL signed_ovf_rem: got %h expected 0", res); end
      finish_op();
      run_op({32{8'hF9}}, {32{8'h02}}, 3'b000, 1'b0, res, lat);
      exp = {32{8'hFD}};
      checks++;
      if (res !== exp) begin errors++; $display("FAIL signed_quo: got %h expected %h", res, exp); end
      finish_op();
      run_op({32{8'hF9}}, {32{8'h02}}, 3'b000, 1'b1, res, lat);
      exp = {32{8'hFF}};
      checks++;
      if (res !== exp) begin errors++; $display("FAIL signed_rem: got %h expected %h", res, exp); end
      finish_op();
      bus.signed_i = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_sew8();
      test_sew64();
      test_sew32();
      test_div_zero();
      test_reserved();
      test_backpressure();
      test_ignore_inputs();
      test_reset_mid();
`ifdef VDIV_SIGNED_EN
      test_signed();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
